rand_pos_gen: RTL and testbench
===============================

RAND_POS_GEN -- requirements
Module: rand_pos_gen

Interface
REQ-001 SHALL have parameter X_W, default 10, meaning X coordinate width.
REQ-002 SHALL have parameter Y_W, default 9, meaning Y coordinate width.
REQ-003 SHALL have parameters X_MIN/X_MAX, defaults 0/610, meaning inclusive X range.
REQ-004 SHALL have parameters Y_MIN/Y_MAX, defaults 0/480, meaning inclusive Y range.
REQ-005 SHALL have parameter MAX_TRIES, default 8, meaning collision retries before giving up.
REQ-006 SHALL have parameters SEED_X/SEED_Y, defaults 16'hACE1/15'h1F35, meaning LFSR reset seeds.
REQ-007 SHALL have ports: VGA_clk in 1, the single clock; reset in 1, synchronous active-high reset.
REQ-008 SHALL have ports: req in 1, start request pulse; occupied in 1, candidate collides with snake (combinational, same cycle as cand).
REQ-009 SHALL have ports: cand_x out X_W, cand_y out Y_W, candidate under check; cand_vld out 1, candidate presented.
REQ-010 SHALL have ports: randX out X_W, randY out Y_W, accepted position; valid out 1, one-cycle accept pulse; fail out 1, one-cycle give-up pulse; busy out 1.

Function
REQ-011 SHALL step LFSR_X (16-bit Fibonacci, x^16+x^14+x^13+x^11+1) and LFSR_Y (15-bit, x^15+x^14+1) every cycle regardless of state.
REQ-012 SHALL map raw = low X_W bits of LFSR_X: off = raw >= SPAN_X ? raw - SPAN_X : raw, SPAN_X = X_MAX-X_MIN+1, cand = X_MIN+off; same for Y.
REQ-013 SHALL fail elaboration unless 2^(W-1) <= SPAN <= 2^W for each axis, so one subtraction always lands in range.
REQ-014 SHALL implement FSM IDLE -> DRAW -> CHECK -> (IDLE with valid | DRAW retry | IDLE with fail).
REQ-015 IDLE: req=1 -> DRAW, try counter cleared; busy=0 only in IDLE.
REQ-016 DRAW: register cand_x/cand_y from mapping, -> CHECK (one cycle).
REQ-017 CHECK: cand_vld=1; occupied=0 -> randX/randY <= cand, valid=1 next cycle, -> IDLE.
REQ-018 CHECK: occupied=1 and tries+1 < MAX_TRIES -> increment tries, -> DRAW.
REQ-019 CHECK: occupied=1 and tries+1 == MAX_TRIES -> fail=1 next cycle, randX/randY unchanged, -> IDLE.
REQ-020 Latency: req in cycle 0 with first candidate free -> valid=1 in cycle 3.
REQ-021 req while busy SHALL be ignored (no queueing); req in the cycle valid/fail is asserted SHALL start a new draw.
REQ-022 randX/randY SHALL hold last accepted value until next accept.

Reset
REQ-023 reset SHALL win over all other inputs in the same cycle.
REQ-024 On reset: state IDLE, randX=X_MIN, randY=Y_MIN, cand_x/cand_y=0, valid=fail=cand_vld=busy=0, tries=0, LFSR_X=SEED_X, LFSR_Y=SEED_Y.
REQ-025 Reset mid-draw SHALL abort with no valid/fail pulse.

Configuration
REQ-026 With RAND_POS_SEED_LOAD_EN defined, SHALL add ports seed_we in 1, seed_x in 16, seed_y in 15; seed_we=1 loads both LFSRs next cycle (reset has priority).
REQ-027 A loaded all-zero seed SHALL be replaced by the parameter seed for that LFSR (lock-up prevention).
REQ-028 Without RAND_POS_SEED_LOAD_EN the seed ports SHALL not exist and LFSRs reload only on reset.

Structure
REQ-029 Tap masks, default seeds and FSM state enum SHALL live in shared package snake_pkg.
REQ-030 SHALL instantiate sub-module lfsr_step (parametrised width/taps/seed, load port) twice; FSM and mapping stay in rand_pos_gen.

Verification
REQ-031 Reset asserted 2 cycles -> randX=0, randY=0, valid=fail=busy=cand_vld=0.
REQ-032 req at cycle 0, occupied=0 -> cand_vld=1 in cycle 2, valid=1 in cycle 3 only, randX<=610, randY<=480.
REQ-033 req, occupied held 1, MAX_TRIES=8 -> exactly 8 cand_vld cycles, one fail pulse, no valid, randX/randY unchanged.
REQ-034 occupied=1 on first two checks then 0 -> valid in cycle 7; req pulsed during busy -> no second result.
REQ-035 RAND_POS_SEED_LOAD_EN, load seed_x=16'h0001 twice across runs -> identical cand sequences; seed_x=0 -> sequence equals SEED_X run.
REQ-036 reset asserted in CHECK -> next cycle IDLE, no valid/fail pulse; 10^5 random accepts all within [X_MIN,X_MAX]x[Y_MIN,Y_MAX].

Source files
------------

// File: rtl/snake_pkg.sv
// Shared constants for the food-position generator: LFSR tap masks, default seeds,
// the generator FSM state type and an elaboration helper for range checking.
package snake_pkg;

  // Fibonacci taps, bit (e-1) set for each polynomial exponent e.
  localparam logic [15:0] LFSR_X_TAPS = 16'hB400;  // x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [14:0] LFSR_Y_TAPS = 15'h6000;  // x^15 + x^14 + 1
  localparam logic [15:0] LFSR_X_SEED = 16'hACE1;
  localparam logic [14:0] LFSR_Y_SEED = 15'h1F35;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAW  = 2'd1,
    ST_CHECK = 2'd2
  } pos_state_t;

  // A single conditional subtraction folds raw into [0, span) only if span is in [2^(w-1), 2^w].
  function automatic bit span_ok(input int w, input int span);
    return (span >= (1 << (w - 1))) && (span <= (1 << w));
  endfunction

endpackage

// File: rtl/rand_pos_gen_if.sv
// Request / collision-check / result bundle between the position generator and its user.
interface rand_pos_gen_if #(
  parameter int X_W = 10,
  parameter int Y_W = 9
) ();
  logic           req;
  logic           occupied;
  logic [X_W-1:0] cand_x;
  logic [Y_W-1:0] cand_y;
  logic           cand_vld;
  logic [X_W-1:0] randX;
  logic [Y_W-1:0] randY;
  logic           valid;
  logic           fail;
  logic           busy;

  modport master (
    output req, occupied,
    input  cand_x, cand_y, cand_vld, randX, randY, valid, fail, busy
  );

  modport slave (
    input  req, occupied,
    output cand_x, cand_y, cand_vld, randX, randY, valid, fail, busy
  );
endinterface

// File: rtl/lfsr_step.sv
// Free-running Fibonacci LFSR with seed-on-reset and an optional parallel load.
// A zero load value would lock the register up, so it is replaced by the seed.
module lfsr_step #(
  parameter int           W     = 16,
  parameter logic [W-1:0] TAPS  = '1,
  parameter logic [W-1:0] SEED  = '1,
  parameter int           OUT_W = W
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             load,
  input  logic [W-1:0]     load_val,
  output logic [OUT_W-1:0] q
);

  logic [W-1:0] state_reg;
  logic [W-1:0] state_next;
  logic         feedback;

  always_comb begin
    feedback   = ^(state_reg & TAPS);
    state_next = {state_reg[W-2:0], feedback};
    if (load) begin
      state_next = (load_val == '0) ? SEED : load_val;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_reg <= SEED;
    end else begin
      state_reg <= state_next;
    end
  end

  assign q = state_reg[OUT_W-1:0];

endmodule

// File: rtl/rand_pos_gen.sv
// Random on-screen position generator: draws LFSR candidates, retries on collision.
// Define RAND_POS_SEED_LOAD_EN to add seed_we/seed_x/seed_y for run-time reseeding.
module rand_pos_gen
  import snake_pkg::*;
#(
  parameter int          X_W       = 10,
  parameter int          Y_W       = 9,
  parameter int          X_MIN     = 0,
  parameter int          X_MAX     = 610,
  parameter int          Y_MIN     = 0,
  parameter int          Y_MAX     = 480,
  parameter int          MAX_TRIES = 8,
  parameter logic [15:0] SEED_X    = LFSR_X_SEED,
  parameter logic [14:0] SEED_Y    = LFSR_Y_SEED
) (
  input  logic        VGA_clk,
  input  logic        reset,
`ifdef RAND_POS_SEED_LOAD_EN
  input  logic        seed_we,
  input  logic [15:0] seed_x,
  input  logic [14:0] seed_y,
`endif
  rand_pos_gen_if.slave bus
);

  localparam int SPAN_X = X_MAX - X_MIN + 1;
  localparam int SPAN_Y = Y_MAX - Y_MIN + 1;
  localparam int TW     = $clog2(MAX_TRIES) + 1;

  localparam logic [X_W:0]   SPAN_X_V = (X_W + 1)'(SPAN_X);
  localparam logic [Y_W:0]   SPAN_Y_V = (Y_W + 1)'(SPAN_Y);
  localparam logic [X_W-1:0] X_MIN_V  = X_W'(X_MIN);
  localparam logic [Y_W-1:0] Y_MIN_V  = Y_W'(Y_MIN);
  localparam logic [TW-1:0]  LAST_TRY = TW'(MAX_TRIES - 1);

  if (!span_ok(X_W, SPAN_X) || X_W > 16 || X_MAX >= (1 << X_W)) begin : gen_bad_x_range
    $error("rand_pos_gen: X range does not fit a single-subtraction fold into X_W bits");
  end
  if (!span_ok(Y_W, SPAN_Y) || Y_W > 15 || Y_MAX >= (1 << Y_W)) begin : gen_bad_y_range
    $error("rand_pos_gen: Y range does not fit a single-subtraction fold into Y_W bits");
  end
  if (MAX_TRIES < 1) begin : gen_bad_tries
    $error("rand_pos_gen: MAX_TRIES must be at least 1");
  end

  logic        load_en;
  logic [15:0] load_x;
  logic [14:0] load_y;

`ifdef RAND_POS_SEED_LOAD_EN
  assign load_en = seed_we;
  assign load_x  = seed_x;
  assign load_y  = seed_y;
`else
  assign load_en = 1'b0;
  assign load_x  = '0;
  assign load_y  = '0;
`endif

  logic [X_W-1:0] lfsr_x_q;
  logic [Y_W-1:0] lfsr_y_q;

  lfsr_step #(.W(16), .TAPS(LFSR_X_TAPS), .SEED(SEED_X), .OUT_W(X_W)) u_lfsr_x (
    .clk(VGA_clk), .srst(reset), .load(load_en), .load_val(load_x), .q(lfsr_x_q)
  );

  lfsr_step #(.W(15), .TAPS(LFSR_Y_TAPS), .SEED(SEED_Y), .OUT_W(Y_W)) u_lfsr_y (
    .clk(VGA_clk), .srst(reset), .load(load_en), .load_val(load_y), .q(lfsr_y_q)
  );

  logic [X_W:0]   raw_x;
  logic [Y_W:0]   raw_y;
  logic [X_W-1:0] map_x;
  logic [Y_W-1:0] map_y;

  always_comb begin
    raw_x = {1'b0, lfsr_x_q};
    raw_y = {1'b0, lfsr_y_q};
    map_x = X_MIN_V + ((raw_x >= SPAN_X_V) ? X_W'(raw_x - SPAN_X_V) : lfsr_x_q);
    map_y = Y_MIN_V + ((raw_y >= SPAN_Y_V) ? Y_W'(raw_y - SPAN_Y_V) : lfsr_y_q);
  end

  pos_state_t     state_reg, state_next;
  logic [TW-1:0]  tries_reg, tries_next;
  logic [X_W-1:0] cand_x_reg, cand_x_next;
  logic [Y_W-1:0] cand_y_reg, cand_y_next;
  logic [X_W-1:0] rand_x_reg, rand_x_next;
  logic [Y_W-1:0] rand_y_reg, rand_y_next;
  logic           valid_reg, valid_next;
  logic           fail_reg, fail_next;

  always_comb begin
    state_next  = state_reg;
    tries_next  = tries_reg;
    cand_x_next = cand_x_reg;
    cand_y_next = cand_y_reg;
    rand_x_next = rand_x_reg;
    rand_y_next = rand_y_reg;
    valid_next  = 1'b0;
    fail_next   = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        if (bus.req) begin
          state_next = ST_DRAW;
          tries_next = '0;
        end
      end
      ST_DRAW: begin
        cand_x_next = map_x;
        cand_y_next = map_y;
        state_next  = ST_CHECK;
      end
      ST_CHECK: begin
        if (!bus.occupied) begin
          rand_x_next = cand_x_reg;
          rand_y_next = cand_y_reg;
          valid_next  = 1'b1;
          state_next  = ST_IDLE;
        end else if (tries_reg == LAST_TRY) begin
          fail_next  = 1'b1;
          state_next = ST_IDLE;
        end else begin
          tries_next = tries_reg + TW'(1);
          state_next = ST_DRAW;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge VGA_clk) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      tries_reg  <= '0;
      cand_x_reg <= '0;
      cand_y_reg <= '0;
      rand_x_reg <= X_MIN_V;
      rand_y_reg <= Y_MIN_V;
      valid_reg  <= 1'b0;
      fail_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      tries_reg  <= tries_next;
      cand_x_reg <= cand_x_next;
      cand_y_reg <= cand_y_next;
      rand_x_reg <= rand_x_next;
      rand_y_reg <= rand_y_next;
      valid_reg  <= valid_next;
      fail_reg   <= fail_next;
    end
  end

  assign bus.cand_x   = cand_x_reg;
  assign bus.cand_y   = cand_y_reg;
  assign bus.cand_vld = (state_reg == ST_CHECK);
  assign bus.randX    = rand_x_reg;
  assign bus.randY    = rand_y_reg;
  assign bus.valid    = valid_reg;
  assign bus.fail     = fail_reg;
  assign bus.busy     = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_rand_pos_gen.sv
// Scoreboard bench for rand_pos_gen: the driver predicts candidates/results from a
// polynomial LFSR model and queues them; a negedge monitor pops and compares.
module tb_rand_pos_gen;

  localparam int X_W       = 10;
  localparam int Y_W       = 9;
  localparam int X_MIN     = 0;
  localparam int X_MAX     = 610;
  localparam int Y_MIN     = 0;
  localparam int Y_MAX     = 480;
  localparam int MAX_TRIES = 8;
  localparam int SEED_X    = 'hACE1;
  localparam int SEED_Y    = 'h1F35;

  typedef struct { int cyc; int x; int y; } cand_t;
  typedef struct { int cyc; bit is_fail; int x; int y; } res_t;

  logic clk;
  logic reset;
`ifdef RAND_POS_SEED_LOAD_EN
  logic        seed_we;
  logic [15:0] seed_x;
  logic [14:0] seed_y;
`endif

  rand_pos_gen_if #(.X_W(X_W), .Y_W(Y_W)) bus ();

  rand_pos_gen #(
    .X_W(X_W), .Y_W(Y_W), .X_MIN(X_MIN), .X_MAX(X_MAX), .Y_MIN(Y_MIN), .Y_MAX(Y_MAX),
    .MAX_TRIES(MAX_TRIES), .SEED_X(16'hACE1), .SEED_Y(15'h1F35)
  ) dut (
    .VGA_clk(clk),
    .reset(reset),
`ifdef RAND_POS_SEED_LOAD_EN
    .seed_we(seed_we),
    .seed_x(seed_x),
    .seed_y(seed_y),
`endif
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int step_x(input int s);
    int taps[4] = '{16, 14, 13, 11};
    int fb = 0;
    foreach (taps[i]) fb ^= (s >> (taps[i] - 1)) & 1;
    return ((s << 1) | fb) & 'hFFFF;
  endfunction

  function automatic int step_y(input int s);
    int taps[2] = '{15, 14};
    int fb = 0;
    foreach (taps[i]) fb ^= (s >> (taps[i] - 1)) & 1;
    return ((s << 1) | fb) & 'h7FFF;
  endfunction

  function automatic int adv_x(input int s, input int n);
    int v = s;
    for (int i = 0; i < n; i++) v = step_x(v);
    return v;
  endfunction

  function automatic int adv_y(input int s, input int n);
    int v = s;
    for (int i = 0; i < n; i++) v = step_y(v);
    return v;
  endfunction

  function automatic int fold(input int s, input int w, input int lo, input int hi);
    int raw  = s % (1 << w);
    int span = hi - lo + 1;
    return lo + ((raw >= span) ? raw - span : raw);
  endfunction

  int cyc = 0;
  int mx, my;
  logic rst_d = 1'b0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_d <= reset;
    if (reset) begin
      mx <= SEED_X;
      my <= SEED_Y;
    end
`ifdef RAND_POS_SEED_LOAD_EN
    else if (seed_we) begin
      mx <= (seed_x == 16'd0) ? SEED_X : int'(seed_x);
      my <= (seed_y == 15'd0) ? SEED_Y : int'(seed_y);
    end
`endif
    else begin
      mx <= step_x(mx);
      my <= step_y(my);
    end
  end

  // ---------------- scoreboard ----------------
  cand_t cand_q[$];
  res_t  res_q[$];
  int    checks = 0;
  int    errors = 0;
  int    exp_rx = X_MIN;
  int    exp_ry = Y_MIN;
  bit    done = 1'b0;
  bit    done_seen = 1'b0;
  cand_t ce;
  res_t  re;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_d) begin
      chk("rst_valid", int'(bus.valid), 0);
      chk("rst_fail", int'(bus.fail), 0);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_cand_vld", int'(bus.cand_vld), 0);
      chk("rst_randX", int'(bus.randX), X_MIN);
      chk("rst_randY", int'(bus.randY), Y_MIN);
      chk("rst_cand_x", int'(bus.cand_x), 0);
      chk("rst_cand_y", int'(bus.cand_y), 0);
      exp_rx = X_MIN;
      exp_ry = Y_MIN;
    end else begin
      if (bus.cand_vld) begin
        if (cand_q.size() == 0) chk("cand_unexpected", 1, 0);
        else begin
          ce = cand_q.pop_front();
          chk("cand_cycle", cyc, ce.cyc);
          chk("cand_x", int'(bus.cand_x), ce.x);
          chk("cand_y", int'(bus.cand_y), ce.y);
          chk("busy_in_check", int'(bus.busy), 1);
        end
      end
      while (cand_q.size() > 0 && cand_q[0].cyc < cyc) begin
        ce = cand_q.pop_front();
        chk("cand_missing_cycle", cyc, ce.cyc);
      end
      if (bus.valid || bus.fail) begin
        if (res_q.size() == 0) chk("result_unexpected", 1, 0);
        else begin
          re = res_q.pop_front();
          chk("result_cycle", cyc, re.cyc);
          chk("fail_flag", int'(bus.fail), int'(re.is_fail));
          chk("valid_flag", int'(bus.valid), int'(!re.is_fail));
          chk("busy_at_result", int'(bus.busy), 0);
          if (!re.is_fail) begin
            exp_rx = re.x;
            exp_ry = re.y;
            chk("randX_in_range", int'(int'(bus.randX) >= X_MIN && int'(bus.randX) <= X_MAX), 1);
            chk("randY_in_range", int'(int'(bus.randY) >= Y_MIN && int'(bus.randY) <= Y_MAX), 1);
          end
          $display("cycle %0d %s randX=%0d randY=%0d", cyc, re.is_fail ? "giveup" : "accept",
                   bus.randX, bus.randY);
        end
      end
      while (res_q.size() > 0 && res_q[0].cyc < cyc) begin
        re = res_q.pop_front();
        chk("result_missing_cycle", cyc, re.cyc);
      end
      chk("randX_hold", int'(bus.randX), exp_rx);
      chk("randY_hold", int'(bus.randY), exp_ry);
    end
    if (done && !done_seen) begin
      chk("cand_q_empty", cand_q.size(), 0);
      chk("res_q_empty", res_q.size(), 0);
      done_seen = 1'b1;
    end
  end

  // ---------------- driver ----------------
  int drv_last_x = X_MIN;
  int drv_last_y = Y_MIN;

  // Issue req now; c = number of occupied answers before a free one (>= MAX_TRIES gives up).
  // Returns at the negedge of the result cycle, where the next req may be issued.
  task automatic do_txn(input int c);
    int t  = cyc;
    int kl = (c < MAX_TRIES) ? c : MAX_TRIES - 1;
    int tr = t + 3 + 2 * kl;
    int sx, sy;
    for (int k = 0; k <= kl; k++) begin
      sx = adv_x(mx, 1 + 2 * k);
      sy = adv_y(my, 1 + 2 * k);
      cand_q.push_back('{t + 2 + 2 * k, fold(sx, X_W, X_MIN, X_MAX), fold(sy, Y_W, Y_MIN, Y_MAX)});
    end
    if (c < MAX_TRIES) begin
      drv_last_x = fold(sx, X_W, X_MIN, X_MAX);
      drv_last_y = fold(sy, Y_W, Y_MIN, Y_MAX);
      res_q.push_back('{tr, 1'b0, drv_last_x, drv_last_y});
    end else begin
      res_q.push_back('{tr, 1'b1, drv_last_x, drv_last_y});
    end
    bus.req      = 1'b1;
    bus.occupied = 1'($urandom_range(0, 1));
    for (int n = t + 1; n < tr; n++) begin
      @(negedge clk);
      bus.req = ($urandom_range(0, 3) == 0);
      if ((n - t) % 2 == 0) bus.occupied = (((n - t - 2) / 2) < c);
      else                  bus.occupied = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    bus.req      = 1'b0;
    bus.occupied = 1'($urandom_range(0, 1));
  endtask

  // Start a draw, then assert reset (with a competing req) during its CHECK cycle.
  task automatic do_abort();
    int t = cyc;
    cand_q.push_back('{t + 2, fold(adv_x(mx, 1), X_W, X_MIN, X_MAX),
                       fold(adv_y(my, 1), Y_W, Y_MIN, Y_MAX)});
    bus.req = 1'b1;
    @(negedge clk);
    bus.req = 1'b0;
    @(negedge clk);
    reset        = 1'b1;
    bus.req      = 1'b1;
    bus.occupied = 1'b0;
    @(negedge clk);
    reset      = 1'b0;
    bus.req    = 1'b0;
    drv_last_x = X_MIN;
    drv_last_y = Y_MIN;
  endtask

  initial begin
    reset        = 1'b1;
    bus.req      = 1'b0;
    bus.occupied = 1'b0;
`ifdef RAND_POS_SEED_LOAD_EN
    seed_we = 1'b0;
    seed_x  = '0;
    seed_y  = '0;
`endif
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    do_txn(0);                      // free first try
    repeat (2) @(negedge clk);
    do_txn(2);                      // two collisions, strays during busy
    @(negedge clk);
    do_txn(MAX_TRIES);              // give up after every try
    do_txn(0);                      // req in the fail cycle
    do_txn(30);                     // give up again, position held
    @(negedge clk);
    do_abort();
    do_txn(1);

`ifdef RAND_POS_SEED_LOAD_EN
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      seed_x  = (r < 2) ? 16'h0001 : 16'h0000;
      seed_y  = (r < 2) ? 15'h0001 : 15'h0000;
      seed_we = 1'b1;
      @(negedge clk);
      seed_we = 1'b0;
      do_txn(3);
    end
`endif

    for (int i = 0; i < 300; i++) begin
      do_txn($urandom_range(0, 9));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    done = 1'b1;
    for (int i = 0; i < 10 && !done_seen; i++) @(negedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
